// File: rtl/sram_port_master.sv
// sram_port_master: valid/ready host initiator for a 1rw SRAM macro port.
// Optional write-verify read-back is enabled by SRAM_WR_VERIFY_EN.
module sram_port_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  wr_done,
  output logic                  wr_err,
  output logic                  busy,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  typedef enum logic [2:0] {
    IDLE, CMD, WAIT, RESP, VCMD, VWAIT
  } state_e;

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic                  rdy_q, rdy_d;
  logic                  rv_q, rv_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
`ifdef SRAM_WR_VERIFY_EN
  logic                  err_q, err_d;
`endif

  // next state and next registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    addr0_d = addr0_q;
    din0_d  = din0_q;
    rdy_d   = 1'b0;
    rv_d    = rv_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
`ifdef SRAM_WR_VERIFY_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid && rdy_q) begin
          state_d = CMD;
          we_d    = req_we;
          csb_d   = 1'b0;
          web_d   = ~req_we;
          addr0_d = req_addr;
          din0_d  = req_wdata;
        end else begin
          rdy_d = 1'b1;
        end
      end
      CMD: begin
        if (we_q) begin
`ifdef SRAM_WR_VERIFY_EN
          state_d = VCMD;
          csb_d   = 1'b0;
`else
          state_d = IDLE;
          done_d  = 1'b1;
          rdy_d   = 1'b1;
`endif
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_M1;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = RESP;
          rv_d    = 1'b1;
          rdata_d = dout0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rv_d    = 1'b0;
          rdy_d   = 1'b1;
        end
      end
`ifdef SRAM_WR_VERIFY_EN
      VCMD: begin
        state_d = VWAIT;
        cnt_d   = LAT_M1;
      end
      VWAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = (dout0 != din0_q);
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      addr0_q <= '0;
      din0_q  <= '0;
      rdy_q   <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      addr0_q <= addr0_d;
      din0_q  <= din0_d;
      rdy_q   <= rdy_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SRAM_WR_VERIFY_EN
  // verify mismatch flag register
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign wr_err = err_q;
`else
  assign wr_err = 1'b0;
`endif

  assign req_ready = rdy_q;
  assign rsp_valid = rv_q;
  assign rsp_rdata = rdata_q;
  assign wr_done   = done_q;
  assign busy      = busy_q;
  assign csb0      = csb_q;
  assign web0      = web_q;
  assign addr0     = addr0_q;
  assign din0      = din0_q;

endmodule

// File: tb/tb_sram_port_master.sv
// tb_sram_port_master: directed bench, RD_LAT=1 and RD_LAT=3 instances.
// Behavioural macro models; verify checks under SRAM_WR_VERIFY_EN.
module tb_sram_port_master;

  logic        clk0 = 1'b0;
  logic        rstb0;
  always #5 clk0 = ~clk0;

  logic        req_valid, req_ready, req_we;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        wr_done, wr_err, busy, csb0, web0;
  logic [6:0]  addr0;
  logic [31:0] din0, dout0;

  logic        q_valid, q_ready, q_we;
  logic [6:0]  q_addr;
  logic [31:0] q_wdata;
  logic        q_rv, q_rr;
  logic [31:0] q_rd;
  logic        q_done, q_err, q_busy, q_csb, q_web;
  logic [6:0]  q_addr0;
  logic [31:0] q_din0, q_dout;

  sram_port_master #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .RD_LAT(1)) dut (
    .clk0(clk0), .rstb0(rstb0),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .wr_done(wr_done), .wr_err(wr_err), .busy(busy),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  sram_port_master #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .RD_LAT(3)) dut3 (
    .clk0(clk0), .rstb0(rstb0),
    .req_valid(q_valid), .req_ready(q_ready), .req_we(q_we),
    .req_addr(q_addr), .req_wdata(q_wdata),
    .rsp_valid(q_rv), .rsp_ready(q_rr), .rsp_rdata(q_rd),
    .wr_done(q_done), .wr_err(q_err), .busy(q_busy),
    .csb0(q_csb), .web0(q_web), .addr0(q_addr0), .din0(q_din0), .dout0(q_dout)
  );

  // macro model, latency 1, with a forced-zero read at addr 10
  logic [31:0] mem1 [128];
  logic [31:0] p1;
  logic        v1 = 1'b0;
  logic        frc10 = 1'b0;
  always @(posedge clk0) begin
    if (!csb0 && !web0) mem1[addr0] <= din0;
    v1 <= !csb0 && web0;
    if (!csb0 && web0) p1 <= (frc10 && addr0 == 7'd10) ? 32'h0 : mem1[addr0];
  end
  assign dout0 = v1 ? p1 : 32'hBAD0BAD0;

  // macro model, latency 3, junk on dout before data is valid
  logic [31:0] mem3 [128];
  logic [31:0] p3 [3];
  logic [2:0]  v3 = 3'b000;
  always @(posedge clk0) begin
    if (!q_csb && !q_web) mem3[q_addr0] <= q_din0;
    v3 <= {v3[1:0], !q_csb && q_web};
    p3[0] <= mem3[q_addr0];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign q_dout = v3[2] ? p3[2] : ((|v3[1:0]) ? 32'h0BADF00D : 32'h0);

  // edge counters of macro strobes and response valid
  int ncs = 0, nwe = 0, nrv = 0;
  always @(posedge clk0) begin
    if (!csb0) ncs++;
    if (!web0) nwe++;
    if (rsp_valid) nrv++;
  end

  int ncmp = 0, nerr = 0;
  int cs0, we0, rv0, n;

`ifdef SRAM_WR_VERIFY_EN
  localparam int WRN = 3;
  localparam int WRCS = 2;
`else
  localparam int WRN = 1;
  localparam int WRCS = 1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk0);
  endtask

  initial begin
    rstb0 = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    q_valid = 1'b0; q_we = 1'b0; q_addr = '0; q_wdata = '0; q_rr = 1'b1;

    repeat (3) tick;
    chk1("rst_csb", csb0, 1'b1);
    chk1("rst_web", web0, 1'b1);
    chk("rst_addr0", 32'(addr0), 32'd0);
    chk("rst_din0", din0, 32'd0);
    chk1("rst_rv", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk1("rst_done", wr_done, 1'b0);
    chk1("rst_err", wr_err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", req_ready, 1'b0);
    chk1("rst_ready3", q_ready, 1'b0);

    rstb0 = 1'b1;
    tick;
    chk1("rdy_after_rst", req_ready, 1'b1);
    chk1("csb_after_rst", csb0, 1'b1);
    chk1("web_after_rst", web0, 1'b1);

    // write 10
    cs0 = ncs; we0 = nwe;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'd10;
    req_wdata = 32'hFACECAFE;
    tick;
    chk1("wr_cmd_csb", csb0, 1'b0);
    chk1("wr_cmd_web", web0, 1'b0);
    chk("wr_cmd_addr0", 32'(addr0), 32'd10);
    chk("wr_cmd_din0", din0, 32'hFACECAFE);
    chk1("wr_cmd_ready", req_ready, 1'b0);
    chk1("wr_cmd_busy", busy, 1'b1);
    req_valid = 1'b0;
    n = 0;
    while (!wr_done && n < 10) begin tick; n++; end
    chk1("wr_done", wr_done, 1'b1);
    chk("wr_lat", 32'(n), 32'(WRN));
    chk1("wr_err0", wr_err, 1'b0);
    tick;
    chk1("wr_done_pulse", wr_done, 1'b0);
    chk1("wr_ready_back", req_ready, 1'b1);
    chk("wr_cs_count", 32'(ncs - cs0), 32'(WRCS));
    chk("wr_we_count", 32'(nwe - we0), 32'd1);

    // read 10
    cs0 = ncs; we0 = nwe;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd10;
    tick;
    chk1("rd_cmd_csb", csb0, 1'b0);
    chk1("rd_cmd_web", web0, 1'b1);
    chk("rd_cmd_addr0", 32'(addr0), 32'd10);
    req_valid = 1'b0;
    tick;
    chk1("rd_wait_rv", rsp_valid, 1'b0);
    tick;
    chk1("rd_rv", rsp_valid, 1'b1);
    chk("rd_data", rsp_rdata, 32'hFACECAFE);
    tick;
    chk1("rd_rv_drop", rsp_valid, 1'b0);
    chk1("rd_ready_back", req_ready, 1'b1);
    chk("rd_cs_count", 32'(ncs - cs0), 32'd1);
    chk("rd_we_count", 32'(nwe - we0), 32'd0);

    // write 127 for the backpressure read
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'd127;
    req_wdata = 32'h12345678;
    tick;
    req_valid = 1'b0;
    n = 0;
    while (!wr_done && n < 10) begin tick; n++; end
    chk1("wr127_done", wr_done, 1'b1);
    tick;

    // backpressure read of 127, stray write offered meanwhile
    rsp_ready = 1'b0; cs0 = ncs;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd127;
    tick;
    req_we = 1'b1; req_addr = 7'd3; req_wdata = 32'h0;
    tick;
    tick;
    chk1("bp_rv", rsp_valid, 1'b1);
    chk("bp_data", rsp_rdata, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk1("bp_rv_hold", rsp_valid, 1'b1);
      chk("bp_data_hold", rsp_rdata, 32'h12345678);
      chk1("bp_ready_low", req_ready, 1'b0);
      chk1("bp_csb_high", csb0, 1'b1);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick;
    chk1("bp_rv_drop", rsp_valid, 1'b0);
    chk1("bp_ready_back", req_ready, 1'b1);
    chk("bp_cs_count", 32'(ncs - cs0), 32'd1);

    // reset during WAIT
    rv0 = nrv;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd10;
    tick;
    req_valid = 1'b0;
    tick;
    rstb0 = 1'b0;
    tick;
    chk1("mrst_rv", rsp_valid, 1'b0);
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_csb", csb0, 1'b1);
    tick;
    rstb0 = 1'b1;
    tick;
    chk1("mrst_ready", req_ready, 1'b1);
    repeat (3) tick;
    chk("mrst_no_rsp", 32'(nrv - rv0), 32'd0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'd10;
    tick;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin tick; n++; end
    chk1("mrst_rd_rv", rsp_valid, 1'b1);
    chk("mrst_rd_data", rsp_rdata, 32'hFACECAFE);
    tick;

    // RD_LAT=3 instance: write addr 0, then read it
    q_valid = 1'b1; q_we = 1'b1; q_addr = 7'd0; q_wdata = 32'hDEADBEEF;
    tick;
    q_valid = 1'b0;
    n = 0;
    while (!q_done && n < 12) begin tick; n++; end
    chk1("l3_wr_done", q_done, 1'b1);
    chk1("l3_wr_err", q_err, 1'b0);
    tick;
    q_valid = 1'b1; q_we = 1'b0; q_addr = 7'd0;
    tick;
    chk1("l3_cmd_csb", q_csb, 1'b0);
    q_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk1("l3_wait_rv", q_rv, 1'b0);
    end
    tick;
    chk1("l3_rv", q_rv, 1'b1);
    chk("l3_data", q_rd, 32'hDEADBEEF);
    tick;
    chk1("l3_rv_drop", q_rv, 1'b0);

`ifdef SRAM_WR_VERIFY_EN
    // verify against a macro that reads addr 10 as zero
    frc10 = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'd10;
    req_wdata = 32'hDEADBEEF;
    tick;
    chk1("v_cmd_csb", csb0, 1'b0);
    chk1("v_cmd_web", web0, 1'b0);
    chk("v_cmd_addr0", 32'(addr0), 32'd10);
    req_valid = 1'b0;
    tick;
    chk1("v_vcmd_csb", csb0, 1'b0);
    chk1("v_vcmd_web", web0, 1'b1);
    chk("v_vcmd_addr0", 32'(addr0), 32'd10);
    tick;
    chk1("v_vwait_done", wr_done, 1'b0);
    tick;
    chk1("v_bad_done", wr_done, 1'b1);
    chk1("v_bad_err", wr_err, 1'b1);
    chk1("v_bad_rv", rsp_valid, 1'b0);
    tick;
    chk1("v_err_pulse", wr_err, 1'b0);
    frc10 = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'd5; req_wdata = 32'h55;
    tick;
    req_valid = 1'b0;
    n = 0;
    while (!wr_done && n < 10) begin tick; n++; end
    chk1("v_ok_done", wr_done, 1'b1);
    chk1("v_ok_err", wr_err, 1'b0);
    tick;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
